regfile_write_arbiter: RTL

//  Shares the register file's single write port among NUM_REQ write-back sources (ALU, load, mul/div).

---
 rtl/regfile_write_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among write-back sources.
// One registered output stage; writes to $zero are consumed and counted, never forwarded.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      rf_busy,
    output logic [ADDR_W-1:0]         write_reg,
    output logic [DATA_W-1:0]         write_data,
    output logic                      reg_write,
    output logic [2:0]                grant_id,
    output logic [15:0]               drop_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic              out_valid;
    logic              can_accept;
    logic              found;
    logic              take;
    logic              take_zero;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  ptr_next;
    logic [IDX_W:0]    scan;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Scan starts at rr_ptr and wraps; the extra bit in scan holds the unwrapped sum.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (scan >= (IDX_W+1)'(NUM_REQ))
                scan = scan - (IDX_W+1)'(NUM_REQ);
            if (!found && req_valid[scan[IDX_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = scan[IDX_W-1:0];
            end
        end
    end

    assign sel_addr   = addr_arr[gnt_idx];
    assign sel_data   = data_arr[gnt_idx];
    assign can_accept = !out_valid || !rf_busy;
    assign take       = can_accept && found;
    assign take_zero  = take && (sel_addr == '0);
    assign ptr_next   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        req_ready = '0;
        if (take)
            req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= EMPTY;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            EMPTY: begin
                if (take && !take_zero)
                    next_state = FULL;
            end
            FULL: begin
                if (!rf_busy)
                    next_state = (take && !take_zero) ? FULL : EMPTY;
            end
            default: next_state = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == FULL);
        reg_write = out_valid;
    end

    // Payload only moves on a real forwarded accept, so it freezes while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_reg  <= '0;
            write_data <= '0;
            grant_id   <= '0;
        end else if (take && !take_zero) begin
            write_reg  <= sel_addr;
            write_data <= sel_data;
            grant_id   <= 3'(gnt_idx);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (take)
            rr_ptr <= ptr_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_count <= '0;
        else if (take_zero)
            drop_count <= drop_count + 16'd1;
    end

endmodule
